execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 206 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage. It computes the ALU result and the branch
// target and registers them, together with the pass-through fields, into the
// EX/MEM buffer outBuf.
// Optional build macro MUL_EN adds a 64-cycle shift-add multiply for alu_op
// 1000. The stage stalls (busy=1, in_ready=0) while the multiply runs. Without
// MUL_EN, alu_op 1000 gives 0, busy is tied 0 and in_ready is tied 1.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  decode-stage handshake; flush squashes the acceptance
//   instruction, pc      raw instruction word and its address
//   rd1, rd2, imm        register operands and sign-extended immediate
//   alu_src, alu_op      operand B select (0 rd2, 1 imm), operation code
//   ctrl                 {RegWrite, MemToReg, MemWrite, MemRead, BNZ, BZ, B, 0}
//   outBuf               {ctrl[7:1], zero, rd2, result, target, instruction}
//   busy                 a multiply is in progress
module execute_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [31:0]  instruction,
    input  logic [63:0]  pc,
    input  logic [63:0]  rd1,
    input  logic [63:0]  rd2,
    input  logic [63:0]  imm,
    input  logic         alu_src,
    input  logic [3:0]   alu_op,
    input  logic [7:0]   ctrl,
    output logic [231:0] outBuf,
    output logic         busy
);
    localparam int unsigned XLEN  = 64;
    localparam int unsigned BUF_W = 232;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LSL = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PSB = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [XLEN-1:0] op_b_c;
    logic [XLEN-1:0] alu_res_c;
    logic [XLEN-1:0] target_c;
    logic            accept_c;
    logic            unused_c;

    // ctrl[0] is a reserved bit and is not forwarded.
    assign unused_c = ctrl[0];

    assign op_b_c   = alu_src ? imm : rd2;
    assign target_c = pc + (imm << 2);
    assign accept_c = in_valid & in_ready & ~flush;

    // Single-cycle ALU. Unlisted codes, including the multiply, give 0.
    always_comb begin
        alu_res_c = '0;
        case (alu_op)
            OP_AND:  alu_res_c = rd1 & op_b_c;
            OP_OR:   alu_res_c = rd1 | op_b_c;
            OP_ADD:  alu_res_c = rd1 + op_b_c;
            OP_SUB:  alu_res_c = rd1 - op_b_c;
            OP_PSB:  alu_res_c = op_b_c;
            OP_NOR:  alu_res_c = ~(rd1 | op_b_c);
            OP_LSL:  alu_res_c = rd1 << op_b_c[5:0];
            OP_LSR:  alu_res_c = rd1 >> op_b_c[5:0];
            default: alu_res_c = '0;
        endcase
    end

    // Assemble one EX/MEM buffer word; the zero flag is derived from the result.
    function automatic logic [BUF_W-1:0] pack_buf(
        input logic [31:0]     ins,
        input logic [XLEN-1:0] tgt,
        input logic [XLEN-1:0] res,
        input logic [XLEN-1:0] r2,
        input logic [6:0]      c7
    );
        return {c7, (res == '0), r2, res, tgt, ins};
    endfunction

`ifdef MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic [XLEN-1:0]  acc, acc_nxt, acc_step_c;
    logic [XLEN-1:0]  mcand, mcand_nxt;
    logic [XLEN-1:0]  mplier, mplier_nxt;
    logic [31:0]      l_ins, l_ins_nxt;
    logic [XLEN-1:0]  l_tgt, l_tgt_nxt;
    logic [XLEN-1:0]  l_rd2, l_rd2_nxt;
    logic [6:0]       l_ctrl, l_ctrl_nxt;
    logic [BUF_W-1:0] buf_nxt;
    logic             in_ready_nxt, busy_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            l_ins    <= '0;
            l_tgt    <= '0;
            l_rd2    <= '0;
            l_ctrl   <= '0;
            outBuf   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            mcand    <= mcand_nxt;
            mplier   <= mplier_nxt;
            l_ins    <= l_ins_nxt;
            l_tgt    <= l_tgt_nxt;
            l_rd2    <= l_rd2_nxt;
            l_ctrl   <= l_ctrl_nxt;
            outBuf   <= buf_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state logic: a bubble is loaded unless an instruction or the product retires.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        l_ins_nxt  = l_ins;
        l_tgt_nxt  = l_tgt;
        l_rd2_nxt  = l_rd2;
        l_ctrl_nxt = l_ctrl;
        buf_nxt    = '0;
        acc_step_c = acc + (mplier[0] ? mcand : XLEN'(0));
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (alu_op == OP_MUL) begin
                        state_nxt  = S_MUL;
                        cnt_nxt    = '0;
                        acc_nxt    = '0;
                        mcand_nxt  = rd1;
                        mplier_nxt = op_b_c;
                        l_ins_nxt  = instruction;
                        l_tgt_nxt  = target_c;
                        l_rd2_nxt  = rd2;
                        l_ctrl_nxt = ctrl[7:1];
                    end else begin
                        buf_nxt = pack_buf(instruction, target_c, alu_res_c, rd2, ctrl[7:1]);
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // One multiplier bit per cycle; the last step retires the product.
                    acc_nxt    = acc_step_c;
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                    if (cnt == 6'd63) begin
                        buf_nxt   = pack_buf(l_ins, l_tgt, acc_step_c, l_rd2, l_ctrl);
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        in_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt     = (state_nxt == S_MUL);
    end
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;

    // EX/MEM buffer: the result on acceptance, a bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outBuf <= '0;
        end else if (accept_c) begin
            outBuf <= pack_buf(instruction, target_c, alu_res_c, rd2, ctrl[7:1]);
        end else begin
            outBuf <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage. The driver pushes the expected response
// for every clock edge, and a monitor pops and compares each one shortly after
// that edge. The model uses plain arithmetic and counts down the edges left
// in a multiply.
module tb_execute_stage;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, flush, alu_src, busy;
    logic [31:0]  instruction;
    logic [63:0]  pc, rd1, rd2, imm;
    logic [3:0]   alu_op;
    logic [7:0]   ctrl;
    logic [231:0] outBuf;

    typedef struct {
        logic [231:0] word;
        logic         rdy;
        logic         bsy;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    bit           m_busy = 1'b0;
    int           m_left = 0;
    logic [231:0] m_res  = '0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .instruction(instruction), .pc(pc), .rd1(rd1), .rd2(rd2),
        .imm(imm), .alu_src(alu_src), .alu_op(alu_op), .ctrl(ctrl),
        .outBuf(outBuf), .busy(busy)
    );

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = b;
            4'd12:   r = ~(a | b);
            4'd3:    r = a << b[5:0];
            4'd4:    r = a >> b[5:0];
            4'd8: begin
`ifdef MUL_EN
                r = a * b;
`else
                r = 64'd0;
`endif
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [231:0] ref_word(input logic [31:0] ins, input logic [63:0] p,
                                              input logic [63:0] im, input logic [63:0] r2,
                                              input logic [63:0] res, input logic [7:0] c);
        logic [63:0] tgt;
        logic        z;
        tgt = p + im * 64'd4;
        z   = (res == 64'd0);
        return {c[7:1], z, r2, res, tgt, ins};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle, then predict what the DUT holds after that edge.
    task automatic step(input bit v, input bit f, input logic [3:0] op, input bit src,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                        input logic [63:0] p, input logic [31:0] ins, input logic [7:0] c);
        exp_t        e;
        logic [63:0] bsel;
        bit          is_mul;
        in_valid = v; flush = f; alu_op = op; alu_src = src;
        rd1 = a; rd2 = b; imm = im; pc = p; instruction = ins; ctrl = c;
        @(posedge clk);
        bsel   = src ? im : b;
        is_mul = 1'b0;
`ifdef MUL_EN
        is_mul = (op == 4'd8);
`endif
        e.word = '0;
        if (m_busy) begin
            if (f) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    e.word = m_res;
                end
            end
        end else if (v && !f) begin
            if (is_mul) begin
                m_busy = 1'b1;
                m_left = 64;
                m_res  = ref_word(ins, p, im, b, ref_alu(op, a, bsel), c);
            end else begin
                e.word = ref_word(ins, p, im, b, ref_alu(op, a, bsel), c);
            end
        end
        e.rdy = !m_busy;
        e.bsy = m_busy;
        sbq.push_back(e);
        #2;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 4'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 32'd0, 8'd0);
    endtask

    // Monitor: compares every predicted edge shortly after it happens.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (outBuf !== e.word || in_ready !== e.rdy || busy !== e.bsy) begin
                    errors++;
                    $display("FAIL sb t=%0t outBuf=%h rdy=%b busy=%b expected outBuf=%h rdy=%b busy=%b",
                             $time, outBuf, in_ready, busy, e.word, e.rdy, e.bsy);
                end
            end
        end
    end

    initial begin
        logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd4, 4'd8, 4'd5, 4'd9, 4'd15};
        logic [3:0] op;
        int         busy_cycles;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_src = 1'b0; alu_op = 4'd0;
        instruction = '0; pc = '0; rd1 = '0; rd2 = '0; imm = '0; ctrl = '0;
        #12;
        chk("reset_outbuf_lo", outBuf[63:0], 64'd0);
        chk("reset_outbuf_hi", 64'(outBuf[231:64] != '0), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // ADD 5 + 7
        step(1'b1, 1'b0, 4'd2, 1'b0, 64'd5, 64'd7, 64'd0, 64'h100, 32'h1234_5678, 8'h80);
        chk("add_result", outBuf[159:96], 64'd12);
        chk("add_zero", 64'(outBuf[224]), 64'd0);
        // SUB 9 - 9 with BZ set
        step(1'b1, 1'b0, 4'd6, 1'b0, 64'd9, 64'd9, 64'd0, 64'h0, 32'hFFFF_FFFF, 8'h04);
        chk("sub_result", outBuf[159:96], 64'd0);
        chk("sub_zero", 64'(outBuf[224]), 64'd1);
        chk("sub_bz", 64'(outBuf[226]), 64'd1);
        // a bubble after an all-ones instruction word
        idle_step();
        chk("bubble_ins", 64'(outBuf[31:0]), 64'd0);
        // branch targets, including wrap-around
        step(1'b1, 1'b0, 4'd0, 1'b1, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 32'h1, 8'h02);
        chk("target_neg", outBuf[95:32], 64'hF0);
        step(1'b1, 1'b0, 4'd0, 1'b1, 64'd1, 64'd2, 64'h3FFF_FFFF_FFFF_FFFF, 64'd4, 32'h2, 8'h02);
        chk("target_wrap", outBuf[95:32], 64'd0);
        // flush together with in_valid while idle
        step(1'b1, 1'b1, 4'd2, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 32'h3, 8'hFE);
        chk("flush_idle", 64'(outBuf != '0), 64'd0);

`ifdef MUL_EN
        // full multiply of 3 and all-ones
        step(1'b1, 1'b0, 4'd8, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h40, 32'hABCD, 8'h80);
        busy_cycles = (busy && !in_ready) ? 1 : 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 4'd2, 1'b0, r64(), r64(), r64(), r64(), $urandom(), 8'hFF);
            if (busy && !in_ready) busy_cycles++;
            if (i < 63) chk("mul_bubble", 64'(outBuf != '0), 64'd0);
        end
        chk("mul_busy_cycles", 64'(busy_cycles), 64'd64);
        chk("mul_product", outBuf[159:96], 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_done_ready", 64'(in_ready), 64'd1);
        // flush at multiply cycle 10
        step(1'b1, 1'b0, 4'd8, 1'b0, 64'd7, 64'd9, 64'd0, 64'd0, 32'h55, 8'h80);
        repeat (9) idle_step();
        step(1'b0, 1'b1, 4'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 32'd0, 8'd0);
        chk("mul_flush_busy", 64'(busy), 64'd0);
        chk("mul_flush_bubble", 64'(outBuf != '0), 64'd0);
        repeat (60) idle_step();
        // asynchronous reset in the middle of a multiply
        step(1'b1, 1'b0, 4'd8, 1'b0, 64'd5, 64'd6, 64'd0, 64'd0, 32'h77, 8'h80);
        repeat (5) idle_step();
`else
        // without the multiplier, alu_op 1000 is a single-cycle zero
        step(1'b1, 1'b0, 4'd8, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h40, 32'hABCD, 8'h80);
        chk("mul_off_result", outBuf[159:96], 64'd0);
        chk("mul_off_zero", 64'(outBuf[224]), 64'd1);
        chk("mul_off_busy", 64'(busy), 64'd0);
        busy_cycles = 0;
        // asynchronous reset with a live buffer
        step(1'b1, 1'b0, 4'd2, 1'b0, 64'd5, 64'd6, 64'd0, 64'd0, 32'h77, 8'h80);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outbuf", 64'(outBuf != '0), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_busy", 64'(busy), 64'd0);
        m_busy = 1'b0;
        m_left = 0;
        #3 rst_n = 1'b1;
        idle_step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 11)];
            if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd2;
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0), op, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : r64(),
                 ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : r64(),
                 r64(), r64(), $urandom(), 8'($urandom()));
        end
        repeat (70) idle_step();
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
